// File: rtl/stopwatch_lap_ctrl_if.sv
// stopwatch_lap_ctrl_if: button inputs and BCD display/status bus of the stopwatch
// master: controller side (buttons in, display/status out); slave: board side.
interface stopwatch_lap_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic btn_ss;
  logic btn_lap;
  logic [4*NUM_DIGITS-1:0] time_bcd;
  logic running;
  logic lap_hold;
  logic tick;
  logic ovf;
  modport master (
    input  btn_ss, btn_lap,
    output time_bcd, running, lap_hold, tick, ovf
  );
  modport slave (
    output btn_ss, btn_lap,
    input  time_bcd, running, lap_hold, tick, ovf
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: debounced start/stop + lap/clear stopwatch with N-digit BCD cascade counter
// Ports: clk (rising edge), rst_n (async, active-low), bus (master modport):
//   btn_ss/btn_lap raw buttons in; time_bcd display, running, lap_hold, tick, sticky ovf out.
// Optional macro STOPWATCH_MMSS_EN: digits 3 and 5 wrap at 5 (MM:SS.hh), needs NUM_DIGITS >= 4.
module stopwatch_lap_ctrl #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_DIGITS = 4,
  parameter int DEB_MS     = 10
) (
  input logic clk,
  input logic rst_n,
  stopwatch_lap_ctrl_if.master bus
);
  localparam int DEB_RAW = (CLK_FREQ / 1000) * DEB_MS;
  localparam int DEB_CYC = DEB_RAW < 1 ? 1 : DEB_RAW;
  localparam int DW      = $clog2(DEB_CYC + 1);
  localparam int DIV     = CLK_FREQ / TICK_HZ;
  localparam int PW      = DIV > 1 ? $clog2(DIV) : 1;
  localparam int W       = 4 * NUM_DIGITS;
  typedef enum logic [1:0] {CLEAR, RUN, STOP, LAP} state_t;
  state_t state, state_nxt;
  logic [1:0] raw, pulse;
  logic ss_p, lap_p, running, tick, wrap, snap_load;
  logic [PW-1:0] ps;
  logic [W-1:0] cnt, cnt_inc, snap;
  assign raw = {bus.btn_lap, bus.btn_ss};
  // Filtered level flips only once the synchronised input has disagreed with it
  // for DEB_CYC+1 consecutive samples, so shorter glitches never get through.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0] sync;
    logic filt, filt_d;
    logic [DW-1:0] dcnt;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sync   <= '0;
        filt   <= 1'b0;
        filt_d <= 1'b0;
        dcnt   <= '0;
      end else begin
        sync   <= {sync[0], raw[b]};
        filt_d <= filt;
        filt   <= sync[1] != filt && dcnt == DW'(DEB_CYC) ? sync[1] : filt;
        dcnt   <= sync[1] == filt || dcnt == DW'(DEB_CYC) ? '0 : dcnt + DW'(1);
      end
    assign pulse[b] = filt & ~filt_d;
  end
  assign ss_p  = pulse[0];
  assign lap_p = pulse[1];
  // Ripple BCD increment; the top bit reports that every digit was at its maximum.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic c;
    logic [3:0] m;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef STOPWATCH_MMSS_EN
      m = (i == 3 || i == 5) ? 4'd5 : 4'd9;
`else
      m = 4'd9;
`endif
      if (c) begin
        r[4*i+:4] = v[4*i+:4] == m ? 4'd0 : v[4*i+:4] + 4'd1;
        c = v[4*i+:4] == m;
      end
    end
    return {c, r};
  endfunction
  assign {wrap, cnt_inc} = bcd_inc(cnt);
  // ss_p is tested first everywhere so a simultaneous lap_p is dropped.
  always_comb begin
    state_nxt = CLEAR;
    case (state)
      CLEAR:   state_nxt = ss_p ? RUN : CLEAR;
      RUN:     state_nxt = ss_p ? STOP : lap_p ? LAP : RUN;
      LAP:     state_nxt = ss_p ? STOP : lap_p ? RUN : LAP;
      STOP:    state_nxt = ss_p ? RUN : lap_p ? CLEAR : STOP;
      default: state_nxt = CLEAR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= CLEAR;
    else state <= state_nxt;
  assign running   = state == RUN || state == LAP;
  assign tick      = running && ps == PW'(DIV - 1);
  assign snap_load = state == RUN && lap_p && !ss_p;
  // Prescaler holds in STOP so a paused partial tick resumes where it left off.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ps           <= '0;
      cnt          <= '0;
      snap         <= '0;
      bus.ovf      <= 1'b0;
      bus.time_bcd <= '0;
    end else begin
      ps           <= state == CLEAR || tick ? '0 : running ? ps + PW'(1) : ps;
      cnt          <= state == CLEAR ? '0 : tick ? cnt_inc : cnt;
      snap         <= state == CLEAR ? '0 : snap_load ? cnt : snap;
      bus.ovf      <= state != CLEAR && (bus.ovf || (tick && wrap));
      bus.time_bcd <= state == LAP ? snap : cnt;
    end
  assign bus.running  = running;
  assign bus.lap_hold = state == LAP;
  assign bus.tick     = tick;
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl: randomized + directed bench against an integer-time reference model
module tb_stopwatch_lap_ctrl;
  localparam int CF = 1000, TH = 100, DM = 1;
  localparam int DIV = CF / TH;
  localparam int DEB = 1;
`ifdef STOPWATCH_MMSS_EN
  localparam int ND2 = 4;
  localparam int MD0 = 6000, MD1 = 6000;
`else
  localparam int ND2 = 2;
  localparam int MD0 = 10000, MD1 = 100;
`endif
  localparam int S_CLR = 0, S_RUN = 1, S_STP = 2, S_LAP = 3;
  logic clk = 0, rst_n = 0, btn_ss = 0, btn_lap = 0;
  always #5 clk = ~clk;
  stopwatch_lap_ctrl_if #(.NUM_DIGITS(4))   if0 ();
  stopwatch_lap_ctrl_if #(.NUM_DIGITS(ND2)) if1 ();
  assign if0.btn_ss  = btn_ss;
  assign if0.btn_lap = btn_lap;
  assign if1.btn_ss  = btn_ss;
  assign if1.btn_lap = btn_lap;
  stopwatch_lap_ctrl #(.CLK_FREQ(CF), .TICK_HZ(TH), .NUM_DIGITS(4), .DEB_MS(DM))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(if0));
  stopwatch_lap_ctrl #(.CLK_FREQ(CF), .TICK_HZ(TH), .NUM_DIGITS(ND2), .DEB_MS(DM))
    u_ovf (.clk(clk), .rst_n(rst_n), .bus(if1));
  logic [15:0] d_t[2];
  logic d_r[2], d_l[2], d_k[2], d_o[2];
  assign d_t[0] = if0.time_bcd;
  assign d_t[1] = 16'(if1.time_bcd);
  assign d_r[0] = if0.running;
  assign d_r[1] = if1.running;
  assign d_l[0] = if0.lap_hold;
  assign d_l[1] = if1.lap_hold;
  assign d_k[0] = if0.tick;
  assign d_k[1] = if1.tick;
  assign d_o[0] = if0.ovf;
  assign d_o[1] = if1.ovf;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic check_range(input string nm, input logic [31:0] got, input logic [31:0] lo, input logic [31:0] hi);
    n_chk++;
    if (!(got >= lo && got <= hi)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h..%0h at %0t", nm, got, lo, hi, $time);
    end
  endtask
  // Reference model: time is an integer count of ticks, converted to BCD for display.
  function automatic logic [15:0] to_bcd(input int v, input int nd);
    logic [15:0] r;
    int p;
    r = '0;
`ifdef STOPWATCH_MMSS_EN
    r = {4'((v / 100) / 10), 4'((v / 100) % 10), 4'((v % 100) / 10), 4'(v % 10)};
`else
    p = 1;
    for (int i = 0; i < nd; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p = p * 10;
    end
`endif
    return r;
  endfunction
  int st_m[2], ph_m[2], t_m[2], sn_m[2];
  int nd[2] = '{4, ND2};
  int md[2] = '{MD0, MD1};
  bit ov_m[2], fl_m[2], pend[2];
  bit hist[2][DEB+3];
  logic [15:0] dp_m[2];
  always @(posedge clk or negedge rst_n) begin
    bit p[2];
    bit same, run, tk;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        fl_m[b] = 0;
        pend[b] = 0;
        for (int j = 0; j < DEB + 3; j++) hist[b][j] = 0;
      end
      for (int k = 0; k < 2; k++) begin
        st_m[k] = S_CLR; ph_m[k] = 0; t_m[k] = 0; sn_m[k] = 0; ov_m[k] = 0; dp_m[k] = '0;
      end
    end else begin
      // A button level is accepted once DEB+1 consecutive samples, two cycles old, agree.
      for (int b = 0; b < 2; b++) begin
        p[b] = pend[b];
        for (int j = DEB + 2; j > 0; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = b == 0 ? btn_ss : btn_lap;
        same = 1;
        for (int j = 3; j <= DEB + 2; j++) if (hist[b][j] != hist[b][2]) same = 0;
        pend[b] = same && hist[b][2] && !fl_m[b];
        if (same) fl_m[b] = hist[b][2];
      end
      for (int k = 0; k < 2; k++) begin
        run = st_m[k] == S_RUN || st_m[k] == S_LAP;
        tk  = run && ph_m[k] == DIV - 1;
        dp_m[k] = to_bcd(st_m[k] == S_LAP ? sn_m[k] : t_m[k], nd[k]);
        if (st_m[k] == S_CLR) begin
          t_m[k] = 0; sn_m[k] = 0; ov_m[k] = 0; ph_m[k] = 0;
        end else begin
          if (st_m[k] == S_RUN && p[1] && !p[0]) sn_m[k] = t_m[k];
          if (tk) begin
            t_m[k]++;
            if (t_m[k] == md[k]) begin t_m[k] = 0; ov_m[k] = 1; end
          end
          if (run) ph_m[k] = tk ? 0 : ph_m[k] + 1;
        end
        case (st_m[k])
          S_CLR: if (p[0]) st_m[k] = S_RUN;
          S_RUN: if (p[0]) st_m[k] = S_STP; else if (p[1]) st_m[k] = S_LAP;
          S_LAP: if (p[0]) st_m[k] = S_STP; else if (p[1]) st_m[k] = S_RUN;
          default: if (p[0]) st_m[k] = S_RUN; else if (p[1]) st_m[k] = S_CLR;
        endcase
      end
    end
  end
  always @(negedge clk) if (chk_en)
    for (int k = 0; k < 2; k++) begin
      bit er;
      er = st_m[k] == S_RUN || st_m[k] == S_LAP;
      check(k ? "u_ovf time_bcd" : "u_dut time_bcd", d_t[k], dp_m[k]);
      check(k ? "u_ovf running" : "u_dut running", d_r[k], er);
      check(k ? "u_ovf lap_hold" : "u_dut lap_hold", d_l[k], st_m[k] == S_LAP);
      check(k ? "u_ovf tick" : "u_dut tick", d_k[k], er && ph_m[k] == DIV - 1);
      check(k ? "u_ovf ovf" : "u_dut ovf", d_o[k], ov_m[k]);
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input bit s, input bit l, input int n);
    @(negedge clk);
    btn_ss = s;
    btn_lap = l;
    repeat (n) @(negedge clk);
    btn_ss = 0;
    btn_lap = 0;
  endtask
  initial begin
    int a, h, n;
    cyc(3);
    chk_en = 1;
    rst_n = 1;
    cyc(2);
    check("reset time_bcd", if0.time_bcd, 0);
    check("reset running", if0.running, 0);
    check("reset lap_hold", if0.lap_hold, 0);
    check("reset ovf", if0.ovf, 0);
    press(1, 0, 4);
    cyc(246);
    check_range("run time_bcd", if0.time_bcd, 'h24, 'h26);
    check("run running", if0.running, 1);
    n = 0;
    while (!if0.tick && n < 40) begin @(negedge clk); n++; end
    check("tick seen", n < 40, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!if0.tick && n < 40);
    check("tick period", n, 10);
    press(0, 1, 4);
    cyc(100);
    check("lap lap_hold", if0.lap_hold, 1);
    check("lap running", if0.running, 1);
    press(0, 1, 4);
    cyc(20);
    check("unlap lap_hold", if0.lap_hold, 0);
    check("unlap running", if0.running, 1);
    press(1, 0, 4);
    cyc(500);
    check("pause running", if0.running, 0);
    press(1, 0, 4);
    cyc(30);
    check("resume running", if0.running, 1);
    press(1, 1, 4);
    cyc(10);
    check("both running", if0.running, 0);
    check("both lap_hold", if0.lap_hold, 0);
    press(0, 1, 4);
    cyc(5);
    check("clear time_bcd", if0.time_bcd, 0);
    check("clear ovf", if0.ovf, 0);
    check("clear running", if0.running, 0);
    press(0, 1, 4);
    cyc(5);
    check("clear lap ignored", if0.running, 0);
    @(negedge clk) btn_ss = 1;
    @(negedge clk) btn_ss = 0;
    cyc(10);
    check("glitch running", if0.running, 0);
    press(1, 0, 4);
    cyc(1050);
`ifndef STOPWATCH_MMSS_EN
    check("wrap ovf", if1.ovf, 1);
`endif
    check("no wrap ovf", if0.ovf, 0);
    check("long running", if0.running, 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst time_bcd", if0.time_bcd, 0);
    check("arst running", if0.running, 0);
    check("arst tick", if0.tick, 0);
    check("arst ovf", if1.ovf, 0);
    check("arst lap_hold", if0.lap_hold, 0);
    cyc(2);
    rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 29);
      if (a == 0) begin
        @(posedge clk);
        #2 rst_n = 0;
        cyc(2);
        rst_n = 1;
      end else begin
        h = $urandom_range(1, 5);
        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h);
      end
      cyc($urandom_range(1, 60));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Parametrised stopwatch controller with debounced start/stop and lap/clear buttons, a configurable-resolution tick prescaler and an N-digit BCD cascade counter. Adds a lap-hold snapshot mode and overflow detection. Drives the BCD time bus consumed by the board's 7-segment multiplex driver.

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz
TICK_HZ, 100, count resolution in Hz (100 gives 10 ms per LSB); CLK_FREQ must be divisible by TICK_HZ
NUM_DIGITS, 4, number of BCD digits; must be at least 2
DEB_MS, 10, button debounce stable time in ms; DEB_CYC = (CLK_FREQ/1000)*DEB_MS, minimum 1

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
BTN_SS  in  1  raw start/stop button, active-high, asynchronous to CLK
BTN_LAP  in  1  raw lap/clear button, active-high, asynchronous to CLK
TIME_BCD  out  4*NUM_DIGITS  displayed time; digit 0 is the least significant nibble
RUNNING  out  1  high in RUN and LAP states
LAP_HOLD  out  1  high in LAP state (display frozen)
TICK  out  1  one-cycle pulse on each counter increment
OVF  out  1  sticky; set when the counter wraps from all-9s to 0

Behaviour:
- Reset (RST=0, asynchronous): state=CLEAR, counter=0, snapshot=0, prescaler=0, debouncers idle, all outputs 0.
- Button path: 2-FF synchroniser, then a debounce counter. The filtered level updates only after the input has been stable for DEB_CYC cycles. A rising edge of the filtered level produces a 1-cycle pulse (ss_p, lap_p). Latency from raw edge to pulse is DEB_CYC+3 cycles.
- FSM states: CLEAR, RUN, STOP, LAP.
  - CLEAR: ss_p -> RUN; lap_p ignored.
  - RUN: ss_p -> STOP; lap_p -> LAP, and the same cycle copies the live counter into the snapshot.
  - LAP: ss_p -> STOP, releasing the display; lap_p -> RUN, releasing the display. The counter keeps running in LAP.
  - STOP: ss_p -> RUN; lap_p -> CLEAR.
  - If ss_p and lap_p fire in the same cycle, ss_p takes priority and lap_p is dropped.
- Prescaler: counts 0..CLK_FREQ/TICK_HZ-1 while in RUN or LAP. TICK is asserted on the terminal count, then the prescaler returns to 0. It holds its value in STOP, so the fractional tick is preserved across pause/resume. It is forced to 0 in CLEAR.
- BCD counter: on TICK, digit 0 increments. A digit at its maximum (9) wraps to 0 and carries into the next digit. When every digit is at maximum, the whole counter wraps to 0 and OVF is set. Counting continues after a wrap.
- CLEAR state: counter=0, snapshot=0, OVF=0, all held every cycle.
- TIME_BCD is registered. It shows the snapshot in LAP and the live counter otherwise. It reflects a counter change on the cycle after the TICK edge.
- RUNNING and LAP_HOLD are decoded from the state register (Moore outputs, no glitches).
- Illegal state encoding recovers to CLEAR on the next clock.
- Reset asserted mid-count returns everything to reset values immediately, with no partial tick.

Optional Feature:
Macro: STOPWATCH_MMSS_EN
- Defined, and requires NUM_DIGITS >= 4:
  - digits 0 and 1 are hundredths of a second, digit 2 is seconds units;
  - digit 3 (seconds tens) and digit 5 (minutes tens, when present) wrap at 5 instead of 9;
  - display reads MM:SS.hh;
  - OVF is set on wrap from the format maximum, e.g. 5959.99 for 6 digits.
- Undefined: every digit wraps at 9 (pure decimal); digit-range logic is not generated.

Test Plan:
Bench overrides: CLK_FREQ=1000, TICK_HZ=100, DEB_MS=1, so 10 cycles per tick and DEB_CYC=1.
- Reset, then one BTN_SS press, wait 250 cycles -> RUNNING=1, TIME_BCD=0x0025 (±1 LSB for button latency), TICK period exactly 10 cycles.
- In RUN, BTN_LAP at count 0x0030, wait 100 cycles -> LAP_HOLD=1, TIME_BCD stays 0x0030. Press BTN_LAP again -> TIME_BCD jumps to live value ≈0x0040.
- Pause at prescaler=4, hold 500 cycles, resume -> TIME_BCD unchanged during pause; next TICK arrives 6 cycles after resume takes effect.
- STOP, then BTN_LAP -> state CLEAR, TIME_BCD=0x0000, OVF=0. Second BTN_LAP in CLEAR -> no state change.
- Preload run to 0x9999 then one more TICK -> TIME_BCD=0x0000, OVF=1 and stays 1 until CLEAR. With STOPWATCH_MMSS_EN, from 0x5999 -> 0x0000 with OVF=1.
- Simultaneous BTN_SS and BTN_LAP edges in RUN -> STOP, snapshot not taken. A 1-cycle glitch on BTN_SS shorter than DEB_CYC+1 -> no transition. Assert RST mid-tick -> all outputs 0 asynchronously.
